// File: rtl/fill_pkg.sv
// Shared types and constants for the frame fill sequencer.
package fill_pkg;

  // Sequencer states: waiting for a request, sweeping the frame, frame complete.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  localparam int FRAME_X_MAX = 159;
  localparam int FRAME_Y_MAX = 119;
  localparam int COLOUR_W    = 3;

  // Stripe colour: each column takes the low bits of its x coordinate,
  // giving eight repeating vertical bands across the frame.
  function automatic logic [COLOUR_W-1:0] stripe_colour(input logic [7:0] x);
    return x[COLOUR_W-1:0];
  endfunction

endpackage

// File: rtl/axis_counter.sv
// Saturating coordinate counter with synchronous clear, used for one axis.
module axis_counter #(
  parameter int W   = 8,
  parameter int MAX = 159
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         count,
  output logic [W-1:0] Q,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment; never steps past MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q      = cnt_q;
  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/fill_sequencer.sv
// Sweeps every pixel of the frame column by column (y inner loop) and
// drives the VGA adapter plot interface, with pause and two colour modes.
module fill_sequencer
  import fill_pkg::*;
#(
  parameter int X_MAX = FRAME_X_MAX,
  parameter int Y_MAX = FRAME_Y_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  input  logic                mode,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                done
);

  fill_state_t         state_q;
  fill_state_t         state_d;
  logic                plot_q;
  logic                plot_d;
  logic                mode_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                latch_en;

  logic                x_load;
  logic                x_count;
  logic                y_load;
  logic                y_count;
  logic [7:0]          x_q;
  logic [6:0]          y_q;
  logic                x_at_max;
  logic                y_at_max;

  axis_counter #(
    .W   (8),
    .MAX (X_MAX)
  ) u_x_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (x_load),
    .count  (x_count),
    .Q      (x_q),
    .at_max (x_at_max)
  );

  axis_counter #(
    .W   (7),
    .MAX (Y_MAX)
  ) u_y_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (y_load),
    .count  (y_count),
    .Q      (y_q),
    .at_max (y_at_max)
  );

  // Next state and counter controls. plot_q records whether the pixel at the
  // current coordinates has already been written: the counters only move on
  // once it has, so a pause never skips or repeats a pixel.
  always_comb begin
    state_d  = state_q;
    plot_d   = 1'b0;
    latch_en = 1'b0;
    x_load   = 1'b0;
    x_count  = 1'b0;
    y_load   = 1'b0;
    y_count  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FILL;
          plot_d   = 1'b1;
          latch_en = 1'b1;
          x_load   = 1'b1;
          y_load   = 1'b1;
        end
      end
      FILL: begin
        if (plot_q) begin
          if (x_at_max && y_at_max) begin
            // Last pixel written; coordinates stay parked at the corner.
            state_d = DONE;
          end else begin
            plot_d = !pause;
            if (y_at_max) begin
              y_load  = 1'b1;
              x_count = 1'b1;
            end else begin
              y_count = 1'b1;
            end
          end
        end else begin
          // Pending pixel not yet written: hold position until unpaused.
          plot_d = !pause;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          x_load  = 1'b1;
          y_load  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Plot strobe, plus mode/colour captured once per fill so mid-sweep
  // changes on the inputs cannot disturb the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plot_q   <= 1'b0;
      mode_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      plot_q <= plot_d;
      if (latch_en) begin
        mode_q   <= mode;
        colour_q <= colour_in;
      end
    end
  end

  // Colour mux built only from registers, so no input reaches the outputs
  // combinationally.
  always_comb begin
    vga_colour = '0;
    if (state_q != IDLE) begin
      vga_colour = mode_q ? colour_q : stripe_colour(x_q);
    end
  end

  assign vga_x    = x_q;
  assign vga_y    = y_q;
  assign vga_plot = plot_q;
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_fill_sequencer.sv
// Randomized bench for fill_sequencer: the stimulus pushes the full expected
// pixel sequence of each fill into a queue; an independent monitor pops and
// compares on every plot strobe.
module tb_fill_sequencer;

  localparam int XN   = 160;
  localparam int YN   = 120;
  localparam int NPIX = XN * YN;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       mode;
  logic [2:0] colour_in;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   plot_count = 0;
  pix_t exp_q[$];

  fill_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .mode       (mode),
    .colour_in  (colour_in),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to time events relative to the start edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every plotted pixel must be the next one the model expects.
  initial begin
    pix_t got;
    pix_t want;
    forever begin
      @(negedge clk);
      if (vga_plot === 1'b1) begin
        plot_count++;
        got.x = vga_x;
        got.y = vga_y;
        got.c = vga_colour;
        chk("plot_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk("pixel", 32'(got), 32'(want));
        end
      end
    end
  end

  // One fill request. Cycle index j counts rising edges since the start edge,
  // so j = 0 is the first cycle after it. Pause windows are given in j.
  task automatic run_fill(input logic m, input logic [2:0] c,
                          input int p1s, input int p1l, input int p2s, input int p2l,
                          input int toggle_at, input int change_at, input int abort_at,
                          input int hold);
    int         s;
    int         j;
    int         pcount;
    bit         finished;
    logic [7:0] px;
    logic [6:0] py;
    start     = 1'b1;
    mode      = m;
    colour_in = c;
    pause     = 1'b0;
    exp_q.delete();
    // Column-major frame: every x, and for each x every y from top to bottom.
    for (int xi = 0; xi < XN; xi++) begin
      for (int yi = 0; yi < YN; yi++) begin
        pix_t p;
        p.x = 8'(xi);
        p.y = 7'(yi);
        p.c = m ? c : 3'(xi % 8);
        exp_q.push_back(p);
      end
    end
    plot_count = 0;
    pcount     = p1l + p2l;
    px         = 8'(p1s / YN);
    py         = 7'(p1s % YN);
    s          = cyc + 1;
    finished   = 1'b0;
    while (!finished) begin
      @(negedge clk);
      j = cyc - s;
      if (j == 0) chk("first_plot", {vga_x, vga_y, vga_plot}, {8'd0, 7'd0, 1'b1});
      if (p1l > 0 && j >= p1s && j < p1s + p1l)
        chk("pause_frozen", {vga_x, vga_y, vga_plot}, {px, py, 1'b0});
      if (p1l > 0 && j == p1s + p1l)
        chk("pause_resume", {vga_x, vga_y, vga_plot}, {px, py, 1'b1});
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async", {vga_x, vga_y, vga_colour, vga_plot, done}, 32'd0);
        chk("plots_before_reset", plot_count, abort_at + 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      // 19200 plot cycles then done, counting the first cycle after the start
      // edge as cycle 1: done is high from cycle 19201 plus one per pause cycle.
      if (done === 1'b1) begin
        chk("done_cycle", j + 1, NPIX + 1 + pcount);
        chk("done_xy", {vga_x, vga_y, vga_plot}, {8'd159, 7'd119, 1'b0});
        finished = 1'b1;
      end else if (j + 1 > NPIX + 1 + pcount + 20) begin
        chk("done_timeout", j + 1, NPIX + 1 + pcount);
        finished = 1'b1;
      end
      pause = !finished && (((j + 1 >= p1s) && (j + 1 < p1s + p1l)) ||
                            ((j + 1 >= p2s) && (j + 1 < p2s + p2l)));
      if (j == toggle_at) start = 1'b0;
      else if (j == toggle_at + 1) start = 1'b1;
      if (j == change_at) begin
        mode      = ~m;
        colour_in = ~c;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("done_hold", {done, vga_plot}, 32'd2);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_return", {done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    chk("plot_total", plot_count, NPIX);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pause     = 1'b0;
    mode      = 1'b0;
    colour_in = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_x", vga_x, 32'd0);
    chk("reset_y", vga_y, 32'd0);
    chk("reset_colour", vga_colour, 32'd0);
    chk("reset_plot", vga_plot, 32'd0);
    chk("reset_done", done, 32'd0);
    rst_n = 1'b1;
    // Idle with noise on pause/mode/colour: nothing may plot or move.
    for (int i = 0; i < 6; i++) begin
      pause     = 1'($urandom);
      mode      = 1'($urandom);
      colour_in = 3'($urandom);
      @(negedge clk);
      chk("idle_quiet", {vga_plot, done, vga_x, vga_y, vga_colour}, 32'd0);
    end
    pause = 1'b0;
    // Fill aborted by reset at pixel (80,60); start stays high across reset.
    run_fill(1'($urandom_range(0, 1)), 3'($urandom), 0, 0, 0, 0, -5, -5, 80 * YN + 60, 0);
    // Stripe fill with start dropped for one cycle mid-sweep.
    run_fill(1'b0, 3'($urandom), 0, 0, 0, 0, 3000 + $urandom_range(0, 5000), -5, -1, 3);
    // Fixed colour 5, inputs changed mid-sweep, pause at (20,50) plus a random pause.
    run_fill(1'b1, 3'b101, 20 * YN + 50, 10, 8000 + $urandom_range(0, 4000),
             $urandom_range(1, 6), -5, 5000, -1, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends even if the design stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
